memctrl_bisr: RTL and testbench
===============================

# memctrl_bisr

Byte-wide 64 KiB SRAM controller with built-in self-test (BIST) and built-in self-repair (BISR). It sits between the host bus (CE/CSB/WEB/OEB strobes) and a 64 × 1K×8 SRAM model whose macro is selected by ADDR[15:10]. A march engine tests the array on request, and faulty addresses are remapped to spare byte registers. Normal accesses then see a fault-free memory.

## Interface
- AW, 16: address width; fixed-fault addresses assume 16.
- NSPARE, 4: number of repair entries (spare bytes).
- CLK  in  1  single clock, rising edge.
- RSTN  in  1  reset, synchronous, active-high (asserted when 1).
- ADDR  in  16  byte address; [15:10] macro, [9:0] offset.
- CE  in  1  access enable, high-active.
- CSB  in  1  chip select, low-active.
- WEB  in  1  write enable, low-active.
- OEB  in  1  output enable, low-active.
- IDATA  in  8  write data.
- BIST_EN  in  1  BIST request, level.
- BIST_MODE  in  3  one-hot algorithm select.
- ODATA  out  8  read data, registered.
- BIST_PASS  out  1  BIST result.

## Operation
- Host access only when CE=1, CSB=0 and the BIST FSM is IDLE.
  - Write: WEB=0; IDATA goes to ADDR.
  - Read: WEB=1, OEB=0; ODATA is loaded from ADDR.
  - WEB=0 takes priority over OEB.
  - Otherwise ODATA holds its value.
- SRAM model faults: offsets 0xF658, 0xECC8, 0xDA58, 0x002E and 0x0034 are stuck-at-0 on all bits. Reads there return 8'h00 and writes are lost.
- Repair table: NSPARE entries of {valid, addr[15:0], data[7:0]}.
  - Every access (host or BIST) whose address matches a valid entry uses that entry's data register instead of the SRAM.
- BIST FSM states: IDLE → RUN → DONE.
  - IDLE→RUN: BIST_EN=1 and BIST_MODE is one of 001, 010, 100. This clears the error/overflow flags and sets BIST_PASS=0.
  - RUN→DONE: last element of the algorithm completes.
  - DONE→IDLE: BIST_EN=0.
  - Any state→IDLE: BIST_EN=0 during RUN aborts the run and forces BIST_PASS=0.
- Algorithms (one operation per cycle, addresses 0x0000..0xFFFF):
  - 001 MATS+: ⇑w00; ⇑(r00,wFF); ⇓(rFF,w00). 5N operations.
  - 010 March C-: ⇑w00; ⇑(r00,wFF); ⇑(rFF,w00); ⇓(r00,wFF); ⇓(rFF,w00); ⇓r00. 10N operations.
  - 100 Checkerboard: ⇑w(55/AA by addr[0]); ⇑r; ⇑w(inverse); ⇑r. 4N operations.
- Read mismatch at an address with no valid entry:
  - If a free entry exists: allocate it (valid=1, addr), load the expected data into it.
  - If none is free: set overflow.
- On entering DONE: BIST_PASS=1 if overflow=0.
- The repair table persists across BIST runs and is cleared only by reset.
- Reset values: ODATA=0, BIST_PASS=0, FSM=IDLE, all entries invalid, flags 0. SRAM contents are not reset.

## Timing
- Write: takes effect at the clock edge where the strobes are sampled.
- Read: ODATA is valid one cycle after the sampling edge.
- Read-after-write to the same address in the next cycle returns the new data.
- A repaired address has the same latency as the SRAM path.
- BIST run length: 5·65536, 10·65536 or 4·65536 cycles for the three modes, plus 1 cycle to DONE.
- Host strobes are ignored from the RUN entry edge through DONE. ODATA holds during BIST.
- Reset mid-BIST: FSM goes to IDLE and the table is cleared on that edge.

## Configuration
- BISR_EN defined: repair table compiled in; behaviour as above.
- BISR_EN undefined:
  - No table; all accesses go to the SRAM.
  - Any BIST mismatch sets the error flag, and BIST_PASS = ~error at DONE.
  - The fixed faults therefore yield BIST_PASS=0.

## Structure
- Shared package memctrl_pkg holds:
  - BIST state enum, mode constants (MODE_MATS, MODE_MARCHC, MODE_CKB), data backgrounds (00/FF/55/AA).
  - Fault address list and the repair-entry struct.
- One sub-module, memctrl_sram: 64K×8 behavioural array with the fixed stuck-at faults and a synchronous read port.

## Test plan
- Reset, write 0x3C to 0x1234, read 0x1234 → ODATA=0x3C one cycle after the read edge; a cycle with OEB=1 leaves ODATA at 0x3C.
- BISR_EN, BIST_MODE=001, BIST_EN=1 until DONE → BIST_PASS=1 and 5 entries needed.
  - With NSPARE=4, overflow gives BIST_PASS=0.
  - With NSPARE=8, BIST_PASS=1.
- NSPARE=8, after MODE 010 pass: random write/read pairs over 300 consecutive addresses from 0xF658, 0xECC8, 0xDA58 and 0x0000 → every read returns the written byte (0x002E and 0x0034 included).
- BISR_EN undefined, MODE 100 → BIST_PASS=0 at DONE; a host read of 0xF658 after writing 0xA5 returns 0x00.
- BIST_EN dropped after 1000 cycles of RUN → FSM IDLE, BIST_PASS=0; a subsequent host write/read of 0x0100 works.
- RSTN=1 during RUN → next cycle: IDLE, table empty, BIST_PASS=0, ODATA=0.

Source files
------------

// File: rtl/memctrl_pkg.sv
// Shared types and constants for the BIST/BISR SRAM controller:
// FSM states, march element table, fixed-fault list and repair entries.
package memctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } bist_state_t;

    localparam logic [2:0] MODE_MATS   = 3'b001;
    localparam logic [2:0] MODE_MARCHC = 3'b010;
    localparam logic [2:0] MODE_CKB    = 3'b100;

    localparam logic [7:0] BG_00 = 8'h00;
    localparam logic [7:0] BG_FF = 8'hFF;
    localparam logic [7:0] BG_55 = 8'h55;
    localparam logic [7:0] BG_AA = 8'hAA;

    localparam int NFAULT = 5;
    localparam logic [15:0] FAULT_ADDR [NFAULT] = '{
        16'hF658, 16'hECC8, 16'hDA58, 16'h002E, 16'h0034
    };

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [7:0]  data;
    } rep_entry_t;

    // One march element: op0 always, op1 only when two=1.
    // ckb inverts the background on odd addresses.
    typedef struct packed {
        logic       last;
        logic       down;
        logic       two;
        logic       r0;
        logic [7:0] d0;
        logic       r1;
        logic [7:0] d1;
        logic       ckb;
    } elem_t;

    function automatic elem_t march_elem(input logic [2:0] mode,
                                         input logic [2:0] idx);
        elem_t e;
        e = '0;
        unique case (1'b1)
            mode[0]: begin
                case (idx)
                    3'd0: e = '{1'b0, 1'b0, 1'b0, 1'b0, BG_00, 1'b0, BG_00, 1'b0};
                    3'd1: e = '{1'b0, 1'b0, 1'b1, 1'b1, BG_00, 1'b0, BG_FF, 1'b0};
                    default: e = '{1'b1, 1'b1, 1'b1, 1'b1, BG_FF, 1'b0, BG_00, 1'b0};
                endcase
            end
            mode[1]: begin
                case (idx)
                    3'd0: e = '{1'b0, 1'b0, 1'b0, 1'b0, BG_00, 1'b0, BG_00, 1'b0};
                    3'd1: e = '{1'b0, 1'b0, 1'b1, 1'b1, BG_00, 1'b0, BG_FF, 1'b0};
                    3'd2: e = '{1'b0, 1'b0, 1'b1, 1'b1, BG_FF, 1'b0, BG_00, 1'b0};
                    3'd3: e = '{1'b0, 1'b1, 1'b1, 1'b1, BG_00, 1'b0, BG_FF, 1'b0};
                    3'd4: e = '{1'b0, 1'b1, 1'b1, 1'b1, BG_FF, 1'b0, BG_00, 1'b0};
                    default: e = '{1'b1, 1'b1, 1'b0, 1'b1, BG_00, 1'b0, BG_00, 1'b0};
                endcase
            end
            mode[2]: begin
                case (idx)
                    3'd0: e = '{1'b0, 1'b0, 1'b0, 1'b0, BG_55, 1'b0, BG_00, 1'b1};
                    3'd1: e = '{1'b0, 1'b0, 1'b0, 1'b1, BG_55, 1'b0, BG_00, 1'b1};
                    3'd2: e = '{1'b0, 1'b0, 1'b0, 1'b0, BG_AA, 1'b0, BG_00, 1'b1};
                    default: e = '{1'b1, 1'b0, 1'b0, 1'b1, BG_AA, 1'b0, BG_00, 1'b1};
                endcase
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic elem_down(input logic [2:0] mode,
                                       input logic [2:0] idx);
        elem_t e;
        e = march_elem(mode, idx);
        return e.down;
    endfunction

    // mask lets a narrower test array alias the 16-bit fault list
    function automatic logic is_fault(input logic [15:0] a,
                                      input logic [15:0] mask);
        logic f;
        f = 1'b0;
        for (int i = 0; i < NFAULT; i++) begin
            if (((a ^ FAULT_ADDR[i]) & mask) == 16'h0) f = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/memctrl_sram.sv
// Behavioural byte-wide SRAM array with synchronous read and the
// fixed stuck-at-0 cells (reads give 00, writes are dropped).
module memctrl_sram
    import memctrl_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    localparam logic [15:0] MASK = 16'((32'd1 << AW) - 1);

    logic [7:0] mem [1 << AW];
    logic       flt;

    assign flt = is_fault(16'(addr), MASK);

    always_ff @(posedge clk) begin
        if (we && !flt) mem[addr] <= wdata;
        rdata <= flt ? 8'h00 : mem[addr];
    end

endmodule

// File: rtl/memctrl_bisr.sv
// SRAM controller with march BIST and spare-byte repair.
// BISR_EN compiles in the repair table; otherwise BIST only reports.
module memctrl_bisr
    import memctrl_pkg::*;
#(
    parameter int AW     = 16,
    parameter int NSPARE = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [AW-1:0] ADDR,
    input  logic          CE,
    input  logic          CSB,
    input  logic          WEB,
    input  logic          OEB,
    input  logic [7:0]    IDATA,
    input  logic          BIST_EN,
    input  logic [2:0]    BIST_MODE,
    output logic [7:0]    ODATA,
    output logic          BIST_PASS
);

    localparam logic [AW-1:0] A_ONE = AW'(1);

    bist_state_t   state, state_nxt;
    logic [2:0]    mode_q, eidx;
    logic          opi, fin;
    logic [AW-1:0] baddr;
    logic          mode_ok, start, abort, go_done, bist_op, host_op;
    logic          host_we, host_re, elem_end, op_rd;
    logic [7:0]    op_d;
    elem_t         el_cur;
    logic [AW-1:0] acc_addr;
    logic          acc_we, sram_we;
    logic [7:0]    acc_wd, sram_rdata, rd_data;
    logic          rd_q, chk_v, mism, fail_d;
    logic [7:0]    chk_exp;

    assign mode_ok = BIST_MODE inside {MODE_MATS, MODE_MARCHC, MODE_CKB};

    always_ff @(posedge CLK) begin
        if (RSTN) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (go_done) state_nxt = ST_DONE;
            end
            ST_DONE: if (!BIST_EN) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        abort   = 1'b0;
        go_done = 1'b0;
        bist_op = 1'b0;
        host_op = 1'b0;
        unique case (state)
            ST_IDLE: begin
                start   = BIST_EN && mode_ok;
                host_op = !start && CE && !CSB;
            end
            ST_RUN: begin
                abort   = !BIST_EN;
                bist_op = BIST_EN && !fin;
                go_done = BIST_EN && fin;
            end
            default: ;
        endcase
    end

    assign host_we  = host_op && !WEB;
    assign host_re  = host_op && WEB && !OEB;
    assign el_cur   = march_elem(mode_q, eidx);
    assign op_rd    = opi ? el_cur.r1 : el_cur.r0;
    assign op_d     = (opi ? el_cur.d1 : el_cur.d0)
                    ^ {8{el_cur.ckb & baddr[0]}};
    assign elem_end = el_cur.down ? (baddr == '0) : (baddr == '1);

    // fin marks the drain cycle that checks the final read
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            mode_q <= '0;
            eidx   <= '0;
            opi    <= 1'b0;
            fin    <= 1'b0;
            baddr  <= '0;
        end else if (start) begin
            mode_q <= BIST_MODE;
            eidx   <= '0;
            opi    <= 1'b0;
            fin    <= 1'b0;
            baddr  <= '0;
        end else if (bist_op) begin
            if (el_cur.two && !opi) begin
                opi <= 1'b1;
            end else begin
                opi <= 1'b0;
                if (!elem_end) begin
                    baddr <= el_cur.down ? baddr - A_ONE : baddr + A_ONE;
                end else if (el_cur.last) begin
                    fin <= 1'b1;
                end else begin
                    eidx  <= eidx + 3'd1;
                    baddr <= elem_down(mode_q, eidx + 3'd1) ? '1 : '0;
                end
            end
        end
    end

    always_comb begin
        acc_addr = ADDR;
        acc_we   = host_we;
        acc_wd   = IDATA;
        if (bist_op) begin
            acc_addr = baddr;
            acc_we   = !op_rd;
            acc_wd   = op_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            rd_q    <= 1'b0;
            chk_v   <= 1'b0;
            chk_exp <= '0;
            ODATA   <= '0;
        end else begin
            rd_q    <= host_re;
            chk_v   <= bist_op && op_rd;
            chk_exp <= op_d;
            if (rd_q) ODATA <= rd_data;
        end
    end

    assign mism = chk_v && (rd_data != chk_exp);

    always_ff @(posedge CLK) begin
        if (RSTN)                BIST_PASS <= 1'b0;
        else if (start || abort) BIST_PASS <= 1'b0;
        else if (go_done)        BIST_PASS <= !fail_d;
    end

`ifdef BISR_EN
    localparam int IW = (NSPARE > 1) ? $clog2(NSPARE) : 1;

    rep_entry_t    tbl [NSPARE];
    logic          hit, has_free, need, ovf_q;
    logic          rd_hit_q, chk_hit;
    logic [IW-1:0] hit_idx, free_idx;
    logic [7:0]    hit_data, rd_rep_q, alloc_d;
    logic [AW-1:0] chk_addr;

    // descending scan so the lowest index wins
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NSPARE - 1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].addr == 16'(acc_addr)) begin
                hit      = 1'b1;
                hit_idx  = IW'(i);
                hit_data = tbl[i].data;
            end
            if (!tbl[i].valid) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign sram_we = acc_we && !hit;
    assign rd_data = rd_hit_q ? rd_rep_q : sram_rdata;
    assign need    = mism && !chk_hit;
    assign fail_d  = ovf_q || (need && !has_free);
    assign alloc_d = (acc_we && acc_addr == chk_addr) ? acc_wd : chk_exp;

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            for (int i = 0; i < NSPARE; i++) tbl[i] <= '0;
            ovf_q    <= 1'b0;
            rd_hit_q <= 1'b0;
            rd_rep_q <= '0;
            chk_hit  <= 1'b0;
            chk_addr <= '0;
        end else begin
            rd_hit_q <= hit;
            rd_rep_q <= hit_data;
            chk_hit  <= hit;
            chk_addr <= acc_addr;
            if (start)                  ovf_q <= 1'b0;
            else if (need && !has_free) ovf_q <= 1'b1;
            if (acc_we && hit) tbl[hit_idx].data <= acc_wd;
            if (need && has_free) begin
                tbl[free_idx] <= '{1'b1, 16'(chk_addr), alloc_d};
            end
        end
    end
`else
    logic err_q;

    assign sram_we = acc_we;
    assign rd_data = sram_rdata;
    assign fail_d  = err_q || mism;

    always_ff @(posedge CLK) begin
        if (RSTN)       err_q <= 1'b0;
        else if (start) err_q <= 1'b0;
        else if (mism)  err_q <= 1'b1;
    end
`endif

    memctrl_sram #(.AW(AW)) u_sram (
        .clk  (CLK),
        .we   (sram_we),
        .addr (acc_addr),
        .wdata(acc_wd),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_memctrl_bisr.sv
// Directed bench for memctrl_bisr on an 11-bit array (fault list
// stays distinct when truncated); checks both BISR_EN builds.
module tb_memctrl_bisr;
    import memctrl_pkg::*;

    localparam int AW = 11;
    localparam int N  = 1 << AW;

    logic          CLK = 1'b0;
    logic          RSTN, CE, CSB, WEB, OEB, BIST_EN;
    logic [AW-1:0] ADDR;
    logic [7:0]    IDATA;
    logic [2:0]    BIST_MODE;
    logic [7:0]    ODATA, ODATA4;
    logic          BIST_PASS, PASS4;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] od;
    logic [7:0] d;
    int         errs;

    always #5 CLK = ~CLK;

    memctrl_bisr #(.AW(AW), .NSPARE(8)) u_dut (
        .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .CSB(CSB),
        .WEB(WEB), .OEB(OEB), .IDATA(IDATA), .BIST_EN(BIST_EN),
        .BIST_MODE(BIST_MODE), .ODATA(ODATA), .BIST_PASS(BIST_PASS)
    );

    memctrl_bisr #(.AW(AW), .NSPARE(4)) u_dut4 (
        .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .CSB(CSB),
        .WEB(WEB), .OEB(OEB), .IDATA(IDATA), .BIST_EN(BIST_EN),
        .BIST_MODE(BIST_MODE), .ODATA(ODATA4), .BIST_PASS(PASS4)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle;
        CE  = 1'b0;
        CSB = 1'b1;
        WEB = 1'b1;
        OEB = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] v);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b0; OEB = 1'b1;
        ADDR = a; IDATA = v;
        tick;
        idle;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
        ADDR = a;
        tick;
        idle;
        tick;
    endtask

    // host read strobes stay asserted to show they are ignored
    task automatic run_bist(input logic [2:0] mode, input int nops,
                            input logic exp_pass, input string tag);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
        ADDR = 11'h234;
        BIST_MODE = mode;
        BIST_EN = 1'b1;
        repeat (nops + 1) tick;
        chk({tag, "_pre"}, 32'(BIST_PASS), 32'd0);
        tick;
        chk({tag, "_state"}, 32'(u_dut.state), 32'(ST_DONE));
        chk({tag, "_pass"}, 32'(BIST_PASS), 32'(exp_pass));
        chk({tag, "_hold"}, 32'(ODATA), 32'(od));
        idle;
        BIST_EN = 1'b0;
        tick;
        chk({tag, "_idle"}, 32'(u_dut.state), 32'(ST_IDLE));
    endtask

    initial begin
        RSTN = 1'b1;
        idle;
        BIST_EN = 1'b0;
        BIST_MODE = 3'b000;
        ADDR = '0;
        IDATA = '0;
        od = '0;
        repeat (3) tick;
        RSTN = 1'b0;
        chk("rst_odata", 32'(ODATA), 32'd0);
        chk("rst_odata4", 32'(ODATA4), 32'd0);
        chk("rst_pass", 32'(BIST_PASS), 32'd0);
        chk("rst_state", 32'(u_dut.state), 32'(ST_IDLE));

        wr(11'h234, 8'h3C);
        rd(11'h234);
        od = 8'h3C;
        chk("rd_3c", 32'(ODATA), 32'(od));

        CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b1;
        ADDR = 11'h234;
        tick;
        idle;
        tick;
        chk("oeb_hold", 32'(ODATA), 32'(od));

        CE = 1'b1; CSB = 1'b0; WEB = 1'b0; OEB = 1'b0;
        ADDR = 11'h235; IDATA = 8'h5A;
        tick;
        WEB = 1'b1;
        tick;
        idle;
        tick;
        od = 8'h5A;
        chk("raw_next", 32'(ODATA), 32'(od));

        wr(11'h236, 8'h77);
        CE = 1'b1; CSB = 1'b1; WEB = 1'b1; OEB = 1'b0;
        ADDR = 11'h236;
        tick;
        idle;
        tick;
        chk("csb_hold", 32'(ODATA), 32'(od));

`ifdef BISR_EN
        run_bist(MODE_MATS, 5 * N, 1'b1, "mats8");
        chk("mats4_ovf", 32'(PASS4), 32'd0);
        run_bist(MODE_MARCHC, 10 * N, 1'b1, "marchc");
        foreach (FAULT_ADDR[k]) begin
            if (k == 3) continue;
            errs = 0;
            for (int i = 0; i < 300; i++) begin
                d = 8'($urandom);
                wr(AW'((k == 4 ? 16'h0000 : FAULT_ADDR[k]) + 16'(i)), d);
                rd(AW'((k == 4 ? 16'h0000 : FAULT_ADDR[k]) + 16'(i)));
                if (ODATA !== d) errs++;
                od = d;
            end
            chk($sformatf("rw_%0h", k == 4 ? 16'h0 : FAULT_ADDR[k]),
                32'(errs), 32'd0);
        end
`else
        run_bist(MODE_CKB, 4 * N, 1'b0, "ckb");
        chk("ckb4_pass", 32'(PASS4), 32'd0);
        wr(11'h658, 8'hA5);
        rd(11'h658);
        od = 8'h00;
        chk("flt_rd", 32'(ODATA), 32'(od));
`endif

        BIST_MODE = MODE_MATS;
        BIST_EN = 1'b1;
        repeat (1001) tick;
        BIST_EN = 1'b0;
        tick;
        chk("abort_state", 32'(u_dut.state), 32'(ST_IDLE));
        chk("abort_pass", 32'(BIST_PASS), 32'd0);
        wr(11'h100, 8'hC3);
        rd(11'h100);
        od = 8'hC3;
        chk("abort_rw", 32'(ODATA), 32'(od));

        BIST_MODE = MODE_MARCHC;
        BIST_EN = 1'b1;
        repeat (50) tick;
        RSTN = 1'b1;
        tick;
        chk("midrst_state", 32'(u_dut.state), 32'(ST_IDLE));
        chk("midrst_pass", 32'(BIST_PASS), 32'd0);
        chk("midrst_odata", 32'(ODATA), 32'd0);
        RSTN = 1'b0;
        BIST_EN = 1'b0;
        tick;
        wr(11'h658, 8'hA5);
        rd(11'h658);
        chk("midrst_tbl", 32'(ODATA), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
